// File: rtl/soc_system_pll_lock_ctrl_pkg.sv
// Shared types and elaboration helpers for the PLL lock supervisor.
// Imported by the supervisor top; the CDC cell stays package-free for reuse.
package soc_system_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE  = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  function automatic int clog2(input longint value);
    int     result;
    longint span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/soc_system_pll_lock_ctrl_if.sv
// PLL-side and system-side signals of the lock supervisor.
// The supervisor uses the slave view; the PLL wrapper or bench uses the master view.
interface soc_system_pll_lock_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             locked;
  logic             relock_req;
  logic             pll_rst;
  logic             sys_rst;
  logic             lock_stable;
  logic             fault;
  logic [CNT_W-1:0] relock_count;

  modport master (
    output locked, relock_req,
    input  pll_rst, sys_rst, lock_stable, fault, relock_count
  );

  modport slave (
    input  locked, relock_req,
    output pll_rst, sys_rst, lock_stable, fault, relock_count
  );
endinterface

// File: rtl/soc_system_pll_lock_ctrl_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module soc_system_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/soc_system_pll_lock_ctrl.sv
// PLL lock supervisor: sequences the PLL reset, debounces lock and gates the system reset.
// Clocked by the free-running reference so it keeps working while the PLL is down.
module soc_system_pll_lock_ctrl
  import soc_system_pll_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 8
) (
  input logic                      refclk,
  input logic                      rst,
  soc_system_pll_lock_ctrl_if.slave bus
);
  localparam int TMR_RAW = clog2(max_of(max_of(RST_CYCLES, LOCK_TIMEOUT), STABLE_CYCLES));
  localparam int TMR_W   = (TMR_RAW < 1) ? 1 : TMR_RAW;
  localparam int RTY_W   = clog2(MAX_RETRIES + 1);

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT    = RTY_W'(MAX_RETRIES);

  pll_state_e       state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [RTY_W-1:0] retries, retries_nxt;
  logic [CNT_W-1:0] relocks, relocks_nxt;
  logic             lk_s;
  logic             pll_rst_q, sys_rst_q, lock_stable_q, fault_q;

  soc_system_sync_bit u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.locked),
    .q   (lk_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state   <= RESET_PLL;
      timer   <= '0;
      retries <= '0;
      relocks <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      retries <= retries_nxt;
      relocks <= relocks_nxt;
    end
  end

  // One shared timer: every state change clears it, so each state measures from its own entry.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 1'b1;
    retries_nxt = retries;
    relocks_nxt = relocks;
    case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt = DEBOUNCE;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          timer_nxt   = '0;
          retries_nxt = retries + 1'b1;
          state_nxt   = (retries_nxt == RTY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      DEBOUNCE: begin
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt   = RUN;
          timer_nxt   = '0;
          retries_nxt = '0;
        end
      end
      RUN: begin
        timer_nxt = '0;
        if (!lk_s || bus.relock_req) begin
          state_nxt = RESET_PLL;
          if (relocks != '1) relocks_nxt = relocks + 1'b1;
        end
      end
      FAULT: begin
        timer_nxt = '0;
      end
      default: begin
        state_nxt = RESET_PLL;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      lock_stable_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      pll_rst_q     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      sys_rst_q     <= (state_nxt != RUN);
      lock_stable_q <= (state_nxt == RUN);
      fault_q       <= (state_nxt == FAULT);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst      = sys_rst_q;
  assign bus.lock_stable  = lock_stable_q;
  assign bus.fault        = fault_q;
  assign bus.relock_count = relocks;
endmodule

// File: tb/tb_soc_system_pll_lock_ctrl.sv
// Bench for the PLL lock supervisor: randomized PLL behaviour against a phase/age model,
// plus hand-derived timing and saturation checks.
module tb_soc_system_pll_lock_ctrl;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 50;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 3;
  localparam int CNT_W         = 8;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;

  logic refclk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  soc_system_pll_lock_ctrl_if #(.CNT_W(CNT_W)) bus ();

  soc_system_pll_lock_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: which phase the supervisor is in and how many edges it has spent there.
  typedef enum {PH_PLL_HELD, PH_AWAIT, PH_SETTLE, PH_LIVE, PH_DEAD} phase_t;
  phase_t ph      = PH_PLL_HELD;
  int     ph_age  = 0;
  int     fails   = 0;
  int     relocks = 0;
  bit     lk_a    = 1'b0;
  bit     lk_b    = 1'b0;
  bit     seen;

  initial begin
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) begin
        ph = PH_PLL_HELD; ph_age = 0; fails = 0; relocks = 0; lk_a = 0; lk_b = 0;
      end else begin
        seen   = lk_b;
        lk_b   = lk_a;
        lk_a   = bus.locked;
        ph_age = ph_age + 1;
        case (ph)
          PH_PLL_HELD: if (ph_age == RST_CYCLES) begin ph = PH_AWAIT; ph_age = 0; end
          PH_AWAIT: begin
            if (seen) begin
              ph = PH_SETTLE; ph_age = 0;
            end else if (ph_age == LOCK_TIMEOUT) begin
              fails  = fails + 1;
              ph     = (fails == MAX_RETRIES) ? PH_DEAD : PH_PLL_HELD;
              ph_age = 0;
            end
          end
          PH_SETTLE: begin
            if (!seen) begin
              ph = PH_AWAIT; ph_age = 0;
            end else if (ph_age == STABLE_CYCLES) begin
              ph = PH_LIVE; ph_age = 0; fails = 0;
            end
          end
          PH_LIVE: begin
            if (!seen || bus.relock_req) begin
              if (relocks < CNT_MAX) relocks = relocks + 1;
              ph = PH_PLL_HELD; ph_age = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Every cycle, all outputs must match what the model's phase implies.
  always @(negedge refclk) begin
    checkOutput("pll_rst", bus.pll_rst, (ph == PH_PLL_HELD) || (ph == PH_DEAD));
    checkOutput("sys_rst", bus.sys_rst, ph != PH_LIVE);
    checkOutput("lock_stable", bus.lock_stable, ph == PH_LIVE);
    checkOutput("fault", bus.fault, ph == PH_DEAD);
    checkOutput("relock_count", bus.relock_count, relocks);
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge refclk);
    #1;
  endtask

  task automatic waitRun(input int budget);
    int n;
    n = 0;
    @(negedge refclk);
    while (bus.lock_stable !== 1'b1 && n < budget) begin
      @(negedge refclk);
      n++;
    end
    checkOutput("reach_run", bus.lock_stable, 1);
  endtask

  task automatic waitPllFall(input int budget);
    int n;
    n = 0;
    @(negedge refclk);
    while (bus.pll_rst === 1'b1 && n < budget) begin
      @(negedge refclk);
      n++;
    end
    checkOutput("pll_rst_fall", bus.pll_rst, 0);
  endtask

  task automatic countSysRstHigh(output int n);
    n = 0;
    @(negedge refclk);
    while (bus.sys_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge refclk);
    end
  endtask

  task automatic pulseRelock();
    applyStimulus(1);
    bus.relock_req = 1'b1;
    applyStimulus(1);
    bus.relock_req = 1'b0;
  endtask

  task automatic dropWithRelock();
    applyStimulus(1);
    bus.locked = 1'b0;
    applyStimulus(2);
    bus.relock_req = 1'b1;
    applyStimulus(1);
    bus.relock_req = 1'b0;
    bus.locked     = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int rises;
    logic prev;
    bus.locked = 1'b0;
    bus.relock_req = 1'b0;
    rst = 1'b1;

    repeat (3) @(posedge refclk);
    #2;
    checkOutput("rst_pll_rst", bus.pll_rst, 1);
    checkOutput("rst_sys_rst", bus.sys_rst, 1);
    checkOutput("rst_lock_stable", bus.lock_stable, 0);
    checkOutput("rst_fault", bus.fault, 0);
    checkOutput("rst_relock_count", bus.relock_count, 0);

    // Clean bring-up: pll_rst width, then lock 10 cycles after pll_rst falls.
    applyStimulus(1);
    rst = 1'b0;
    n = 0;
    @(negedge refclk);
    while (bus.pll_rst === 1'b1 && n < 20) begin
      n++;
      @(negedge refclk);
    end
    checkOutput("pll_rst_width", n, RST_CYCLES);
    applyStimulus(10);
    bus.locked = 1'b1;
    countSysRstHigh(n);
    checkOutput("lock_to_release", n, 11);
    checkOutput("first_lock_stable", bus.lock_stable, 1);

    // Lock glitch while debouncing restarts the debounce without counting a relock.
    applyStimulus(1);
    rst = 1'b1;
    bus.locked = 1'b0;
    applyStimulus(1);
    rst = 1'b0;
    waitPllFall(20);
    applyStimulus($urandom_range(3, 15));
    bus.locked = 1'b1;
    applyStimulus($urandom_range(1, 6));
    bus.locked = 1'b0;
    applyStimulus(1);
    bus.locked = 1'b1;
    countSysRstHigh(n);
    checkOutput("glitch_release", n, 11);
    checkOutput("glitch_relock_count", bus.relock_count, 0);

    // Lock loss in RUN.
    applyStimulus(1);
    bus.locked = 1'b0;
    n = 0;
    @(negedge refclk);
    while (bus.sys_rst === 1'b0 && n < 10) begin
      n++;
      @(negedge refclk);
    end
    checkOutput("loss_to_sys_rst", n, 3);
    checkOutput("loss_relock_count", bus.relock_count, 1);
    checkOutput("loss_pll_rst", bus.pll_rst, 1);
    applyStimulus(5);
    bus.locked = 1'b1;
    waitRun(200);

    // Permanent lock loss exhausts the retries.
    applyStimulus(1);
    bus.locked = 1'b0;
    prev = bus.pll_rst;
    rises = 0;
    n = 0;
    while (bus.fault !== 1'b1 && n < 400) begin
      @(negedge refclk);
      if (bus.pll_rst === 1'b1 && prev === 1'b0 && bus.fault === 1'b0) rises++;
      prev = bus.pll_rst;
      n++;
    end
    checkOutput("fault_set", bus.fault, 1);
    checkOutput("retry_pulses", rises, MAX_RETRIES);
    bus.locked = 1'b1;
    applyStimulus(60);
    @(negedge refclk);
    checkOutput("fault_sticky", bus.fault, 1);
    checkOutput("fault_pll_rst", bus.pll_rst, 1);
    checkOutput("fault_sys_rst", bus.sys_rst, 1);

    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    waitRun(100);

    // Randomized PLL behaviour from RUN.
    for (int i = 0; i < 30; i++) begin
      int act;
      applyStimulus($urandom_range(1, 15));
      act = $urandom_range(0, 2);
      if (act == 0) begin
        pulseRelock();
        applyStimulus(2);
        pulseRelock();
      end else if (act == 1) begin
        bus.locked = 1'b0;
        applyStimulus($urandom_range(1, 4));
        bus.locked = 1'b1;
        applyStimulus(4);
      end else begin
        dropWithRelock();
      end
      waitRun(300);
    end

    // Async reset while debouncing after a relock.
    pulseRelock();
    applyStimulus(8);
    @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_pll_rst", bus.pll_rst, 1);
    checkOutput("async_sys_rst", bus.sys_rst, 1);
    checkOutput("async_lock_stable", bus.lock_stable, 0);
    checkOutput("async_fault", bus.fault, 0);
    checkOutput("async_relock_count", bus.relock_count, 0);
    applyStimulus(1);
    rst = 1'b0;
    waitRun(100);
    checkOutput("restart_relock_count", bus.relock_count, 0);

    // Relock counter saturation.
    for (int i = 1; i <= 256; i++) begin
      if (i % 3 == 0) dropWithRelock();
      else pulseRelock();
      waitRun(100);
      if (i == 255) checkOutput("count_255", bus.relock_count, 255);
    end
    checkOutput("count_saturated", bus.relock_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
